// File: rtl/mem_budget_pkg.sv
// Shared types and helpers for the budget-regulated memory request arbiter.
package mem_budget_pkg;

    // Widths of the budget counter and the AXI length field. The arbiter's
    // BudgetWidth/LenWidth parameters must keep these values.
    localparam int unsigned BUDGET_W = 16;
    localparam int unsigned LEN_W    = 8;

    typedef logic [BUDGET_W-1:0] budget_t;
    // One extra bit so a full 256-beat burst never wraps on a narrow budget.
    typedef logic [BUDGET_W:0]   cost_t;

    // A configured budget of all ones means the requester is never limited.
    localparam budget_t BUDGET_UNLIMITED = {BUDGET_W{1'b1}};

    // Beats moved by a burst: AXI len encodes beats-1.
    function automatic cost_t cost(input logic [LEN_W-1:0] len);
        return {{(BUDGET_W + 1 - LEN_W){1'b0}}, len} + {{BUDGET_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mem_budget_counter.sv
// Per-requester budget register: refill/debit bookkeeping and eligibility.
module mem_budget_counter
    import mem_budget_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_refill,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic [LEN_W-1:0] i_len,
    input  budget_t          i_budget,
    input  logic             i_grant,
    output logic             o_eligible,
    output logic             o_throttled,
    output budget_t          o_budget_left
);

    budget_t r_budget_left;
    cost_t   w_cost;
    cost_t   w_base;
    cost_t   w_next;
    logic    w_unlimited;
    logic    w_fits;
    logic    w_debit;

    assign w_cost      = cost(i_len);
    assign w_unlimited = (i_budget == BUDGET_UNLIMITED);
    assign w_fits      = ({1'b0, r_budget_left} >= w_cost);
    // Budgets are frozen while regulation is off; unlimited requesters are never charged.
    assign w_debit     = i_grant & i_enable & ~w_unlimited;

    assign o_eligible    = i_valid & (~i_enable | w_unlimited | w_fits);
    assign o_throttled   = i_valid & i_enable & ~w_unlimited & ~w_fits;
    assign o_budget_left = r_budget_left;

    // Next budget: refill takes precedence as the base, a same-cycle debit is charged to the new period.
    always_comb begin
        w_base = i_refill ? {1'b0, i_budget} : {1'b0, r_budget_left};
        w_next = w_base;
        if (w_debit) begin
            // Saturate in case the budget was lowered below an already-granted cost.
            w_next = (w_base >= w_cost) ? (w_base - w_cost) : {(BUDGET_W + 1){1'b0}};
        end else begin
            w_next = w_base;
        end
    end

    // Budget register; cleared on reset so the first refill defines it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_budget_left <= {BUDGET_W{1'b0}};
        end else begin
            r_budget_left <= w_next[BUDGET_W-1:0];
        end
    end

endmodule

// File: rtl/mem_budget_arbiter.sv
// Budget-regulated round-robin arbiter feeding one registered memory request slot.
module mem_budget_arbiter
    import mem_budget_pkg::*;
#(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned IdWidth     = 6,
    parameter int unsigned LenWidth    = LEN_W,
    parameter int unsigned BudgetWidth = BUDGET_W,
    parameter int unsigned PeriodWidth = 16,
    localparam int unsigned IdxWidth   = $clog2(NumReq)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_enable_i,
    input  logic [PeriodWidth-1:0]          period_i,
    input  logic [NumReq*BudgetWidth-1:0]   budget_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq*LenWidth-1:0]      req_len_i,
    input  logic [NumReq*IdWidth-1:0]       req_id_i,
    output logic                            mst_valid_o,
    input  logic                            mst_ready_i,
    output logic [AddrWidth-1:0]            mst_addr_o,
    output logic [LenWidth-1:0]             mst_len_o,
    output logic [IdWidth+IdxWidth-1:0]     mst_id_o,
    output logic [NumReq*BudgetWidth-1:0]   budget_left_o,
    output logic [NumReq-1:0]               throttled_o
);

    localparam logic [IdxWidth-1:0]    IDX_ONE    = IdxWidth'(32'd1);
    localparam logic [IdxWidth-1:0]    LAST_IDX   = IdxWidth'(NumReq - 32'd1);
    localparam logic [PeriodWidth-1:0] PERIOD_ONE = PeriodWidth'(32'd1);

    logic [PeriodWidth-1:0]        r_period_cnt;
    logic [IdxWidth-1:0]           r_rr;
    logic                          r_mst_valid;
    logic [AddrWidth-1:0]          r_mst_addr;
    logic [LenWidth-1:0]           r_mst_len;
    logic [IdWidth+IdxWidth-1:0]   r_mst_id;

    logic                          w_refill;
    logic                          w_slot_free;
    logic                          w_found;
    logic                          w_accept;
    logic [IdxWidth-1:0]           w_grant_idx;
    logic [NumReq-1:0]             w_eligible;
    logic [NumReq-1:0]             w_ready;
    logic [IdxWidth-1:0]           w_scan [NumReq];
    logic [AddrWidth-1:0]          w_addr [NumReq];
    logic [LenWidth-1:0]           w_len  [NumReq];
    logic [IdWidth-1:0]            w_id   [NumReq];

    assign w_refill    = (r_period_cnt == {PeriodWidth{1'b0}});
    assign w_slot_free = ~r_mst_valid | mst_ready_i;
    assign w_accept    = w_found & w_slot_free & ~rst_i;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
        // Scan order starting at the round-robin pointer.
        assign w_scan[gi] = IdxWidth'((32'(r_rr) + 32'(gi)) % NumReq);
        assign w_addr[gi] = req_addr_i[gi*AddrWidth +: AddrWidth];
        assign w_len[gi]  = req_len_i[gi*LenWidth +: LenWidth];
        assign w_id[gi]   = req_id_i[gi*IdWidth +: IdWidth];

        mem_budget_counter u_counter (
            .i_clk         (clk_i),
            .i_rst         (rst_i),
            .i_refill      (w_refill),
            .i_enable      (cfg_enable_i),
            .i_valid       (req_valid_i[gi]),
            .i_len         (w_len[gi]),
            .i_budget      (budget_i[gi*BudgetWidth +: BudgetWidth]),
            .i_grant       (w_ready[gi]),
            .o_eligible    (w_eligible[gi]),
            .o_throttled   (throttled_o[gi]),
            .o_budget_left (budget_left_o[gi*BudgetWidth +: BudgetWidth])
        );
    end

    // Round-robin pick: first eligible requester at or after the pointer.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = {IdxWidth{1'b0}};
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_grant_idx = (w_eligible[w_scan[k]] && !w_found) ? w_scan[k] : w_grant_idx;
            w_found     = w_found | w_eligible[w_scan[k]];
        end
    end

    // One-hot ready towards the winner, only when the output slot can take it.
    always_comb begin
        w_ready              = {NumReq{1'b0}};
        w_ready[w_grant_idx] = w_accept;
    end

    assign req_ready_o = w_ready;

    // Regulation period: counts down to zero, then refills; a period of 0 refills every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_period_cnt <= {PeriodWidth{1'b0}};
        end else if (w_refill) begin
            r_period_cnt <= (period_i == {PeriodWidth{1'b0}}) ? {PeriodWidth{1'b0}}
                                                              : (period_i - PERIOD_ONE);
        end else begin
            r_period_cnt <= r_period_cnt - PERIOD_ONE;
        end
    end

    // Output slot and pointer: payload loads on acceptance and holds until downstream takes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mst_valid <= 1'b0;
            r_mst_addr  <= {AddrWidth{1'b0}};
            r_mst_len   <= {LenWidth{1'b0}};
            r_mst_id    <= {(IdWidth + IdxWidth){1'b0}};
            r_rr        <= {IdxWidth{1'b0}};
        end else if (w_accept) begin
            r_mst_valid <= 1'b1;
            r_mst_addr  <= w_addr[w_grant_idx];
            r_mst_len   <= w_len[w_grant_idx];
            r_mst_id    <= {w_grant_idx, w_id[w_grant_idx]};
            r_rr        <= (w_grant_idx == LAST_IDX) ? {IdxWidth{1'b0}} : (w_grant_idx + IDX_ONE);
        end else if (mst_ready_i) begin
            r_mst_valid <= 1'b0;
        end else begin
            r_mst_valid <= r_mst_valid;
        end
    end

    assign mst_valid_o = r_mst_valid;
    assign mst_addr_o  = r_mst_addr;
    assign mst_len_o   = r_mst_len;
    assign mst_id_o    = r_mst_id;

endmodule
